// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

   localparam int DIV_DEF_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/seq_divider_trial_subtractor.sv
// Combinational trial subtractor: the subtracting counterpart of the ripple adder.
module trial_subtractor #(
   parameter int N = 5
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   output logic [N-1:0] o_diff,
   output logic         o_borrow
);

   assign {o_borrow, o_diff} = {1'b0, i_a} - {1'b0, i_b};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one restoring step per cycle, WIDTH steps
// DONE  | results valid, done pulse; start accepted as in IDLE
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   div_state_t       r_state;
   div_state_t       w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_remo;
   logic             r_busy;
   logic             r_done;
   logic             r_dbz;

   logic [WIDTH:0]   w_trial_a;
   logic [WIDTH:0]   w_diff;
   logic             w_borrow;
   logic             w_accept;
   logic [WIDTH-1:0] w_step_q;
   logic [WIDTH-1:0] w_step_rem;

   assign w_trial_a = {r_rem, r_q[WIDTH-1]};

   trial_subtractor #(.N(WIDTH + 1)) u_sub (
      .i_a      (w_trial_a),
      .i_b      ({1'b0, r_div}),
      .o_diff   (w_diff),
      .o_borrow (w_borrow)
   );

   assign w_accept = start && (r_state != RUN);

   always_comb begin
      w_state_nxt = r_state;
      w_step_q    = {r_q[WIDTH-2:0], ~w_borrow};
      w_step_rem  = w_borrow ? w_trial_a[WIDTH-1:0] : w_diff[WIDTH-1:0];
      unique case (r_state)
         IDLE, DONE: begin
            if (start) w_state_nxt = (divisor == '0) ? DONE : RUN;
            else       w_state_nxt = IDLE;
         end
         RUN: begin
            if (r_cnt == LAST) w_state_nxt = DONE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_rem   <= '0;
         r_q     <= '0;
         r_div   <= '0;
         r_quot  <= '0;
         r_remo  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_dbz   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == RUN);
         r_done  <= (w_state_nxt == DONE);
         if (w_accept) begin
            if (divisor == '0) begin
               r_quot <= '1;
               r_remo <= dividend;
               r_dbz  <= 1'b1;
            end else begin
               r_q   <= dividend;
               r_rem <= '0;
               r_div <= divisor;
               r_cnt <= '0;
               r_dbz <= 1'b0;
            end
         end else if (r_state == RUN) begin
            r_q   <= w_step_q;
            r_rem <= w_step_rem;
            r_cnt <= r_cnt + 1'b1;
            // Visible results change only on the final step, together with done.
            if (r_cnt == LAST) begin
               r_quot <= w_step_q;
               r_remo <= w_step_rem;
            end
         end
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign quotient    = r_quot;
   assign remainder   = r_remo;
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider with a cycle-level arithmetic reference model.
module tb_seq_divider;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: outputs follow from the arithmetic result and the cycle counts.
   int           m_left = 0;
   logic         m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
   logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_left = 0; m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0;
         m_q = '0; m_r = '0;
      end else if (m_busy) begin
         m_left--;
         if (m_left == 0) begin
            m_busy = 1'b0; m_done = 1'b1; m_q = p_q; m_r = p_r;
         end
      end else begin
         m_done = 1'b0;
         if (start) begin
            if (divisor == 0) begin
               m_done = 1'b1; m_q = '1; m_r = dividend; m_dbz = 1'b1;
            end else begin
               m_busy = 1'b1; m_left = W; m_dbz = 1'b0;
               p_q = W'(dividend / divisor);
               p_r = W'(dividend % divisor);
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (chk_en)
         check("cycle {busy,done,dbz,q,r}",
               {19'd0, busy, done, div_by_zero, quotient, remainder},
               {19'd0, m_busy, m_done, m_dbz, m_q, m_r});
   end

   task automatic wait_done();
      bit ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("done_timeout", {31'd0, ok}, 32'd1);
   endtask

   task automatic drive_start(input logic [W-1:0] dd, input logic [W-1:0] dv);
      start = 1'b1; dividend = dd; divisor = dv;
      @(negedge clk);
      start = 1'b0; dividend = $urandom_range(15, 0); divisor = $urandom_range(15, 0);
   endtask

   task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv);
      @(negedge clk);
      drive_start(dd, dv);
      wait_done();
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("reset outputs", {27'd0, busy, done, div_by_zero, quotient != 0, remainder != 0}, 32'd0);
      rst_n = 1'b1;

      // 13/3: busy four cycles then done
      @(negedge clk);
      drive_start(4'd13, 4'd3);
      repeat (3) @(negedge clk);
      check("13/3 busy before done", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("13/3 done on 5th cycle", {31'd0, done}, 32'd1);
      check("13/3 quotient", 32'(quotient), 32'd4);
      check("13/3 remainder", 32'(remainder), 32'd1);
      check("13/3 dbz", 32'(div_by_zero), 32'd0);

      // 15/1 then 5/7 back-to-back from DONE
      run_op(4'd15, 4'd1);
      check("15/1 quotient", 32'(quotient), 32'd15);
      check("15/1 remainder", 32'(remainder), 32'd0);
      drive_start(4'd5, 4'd7);
      check("b2b busy immediately", {31'd0, busy}, 32'd1);
      wait_done();
      check("5/7 quotient", 32'(quotient), 32'd0);
      check("5/7 remainder", 32'(remainder), 32'd5);

      // divide by zero
      run_op(4'd7, 4'd0);
      check("7/0 quotient", 32'(quotient), 32'hF);
      check("7/0 remainder", 32'(remainder), 32'd7);
      check("7/0 dbz", 32'(div_by_zero), 32'd1);
      check("7/0 busy", 32'(busy), 32'd0);

      // start during RUN is ignored
      @(negedge clk);
      drive_start(4'd9, 4'd2);
      drive_start(4'd1, 4'd1);
      wait_done();
      check("9/2 quotient", 32'(quotient), 32'd4);
      check("9/2 remainder", 32'(remainder), 32'd1);

      // reset mid-RUN aborts
      @(negedge clk);
      drive_start(4'd14, 4'd3);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort outputs", {27'd0, busy, done, div_by_zero, quotient != 0, remainder != 0}, 32'd0);
      repeat (6) @(negedge clk);
      check("abort no done", {31'd0, done}, 32'd0);
      run_op(4'd14, 4'd3);
      check("14/3 quotient", 32'(quotient), 32'd4);
      check("14/3 remainder", 32'(remainder), 32'd2);

      // exhaustive sweep with arithmetic invariant
      for (int a = 0; a < 16; a++) begin
         for (int b = 1; b < 16; b++) begin
            run_op(W'(a), W'(b));
            check("invariant q*d+r", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            check("invariant r<d", {31'd0, 32'(remainder) < 32'(b)}, 32'd1);
         end
      end

      @(negedge clk);
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
